// File: rtl/uart_mmio_if.sv
// rtl/uart_mmio_if.sv - CPU register bus between the SAP-2 system bus and uart_mmio
interface uart_mmio_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  cpu_cs;
    logic                  cpu_we;
    logic                  cpu_re;
    logic [1:0]            cpu_addr;
    logic [DATA_WIDTH-1:0] cpu_din;
    logic [DATA_WIDTH-1:0] cpu_dout;

    modport master (output cpu_cs, cpu_we, cpu_re, cpu_addr, cpu_din, input cpu_dout);
    modport slave  (input cpu_cs, cpu_we, cpu_re, cpu_addr, cpu_din, output cpu_dout);
endinterface

// File: rtl/uart_mmio.sv
// rtl/uart_mmio.sv - memory-mapped UART with TX/RX FIFOs, parity, sticky errors and irq
module uart_mmio #(
    parameter int DATA_WIDTH   = 8,
    parameter int FIFO_DEPTH   = 4,
    parameter int CLKS_PER_BIT = 174
) (
    input  logic       clk,
    input  logic       reset_n,
    uart_mmio_if.slave bus,
    input  logic       uart_rx,
    output logic       uart_tx,
    output logic       irq
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [TW-1:0] BIT_END  = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] HALF_END = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_UART_TX_IDLE, S_UART_TX_START, S_UART_TX_SEND_DATA, S_UART_TX_PARITY, S_UART_TX_STOP
    } tx_state_t;
    typedef enum logic [2:0] {
        S_UART_RX_IDLE, S_UART_RX_VALIDATE_START, S_UART_RX_READ_DATA, S_UART_RX_PARITY, S_UART_RX_STOP
    } rx_state_t;

    logic [3:0]            cfg_q, cfg_d;
    logic [2:0]            err_q, err_d;          // {parity_err, frame_err, overrun}
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic [AW-1:0]         tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
    logic [AW-1:0]         rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
    logic [CW-1:0]         tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
    logic                  rx_wr_q, rx_wr_d, rx_frame_set_q, rx_frame_set_d, rx_par_set_q, rx_par_set_d;
    logic [DATA_WIDTH-1:0] tx_mem [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] rx_mem [FIFO_DEPTH];

    tx_state_t             tx_state_q;
    logic [TW-1:0]         tx_tick_q;
    logic [BW-1:0]         tx_bit_q;
    logic [DATA_WIDTH-1:0] tx_shift_q;
    logic                  tx_par_en_q, tx_par_bit_q, uart_tx_q;

    rx_state_t             rx_state_q;
    logic [TW-1:0]         rx_tick_q;
    logic [BW-1:0]         rx_bit_q;
    logic [DATA_WIDTH-1:0] rx_shift_q;
    logic                  rx_meta_q, rx_sync_q, rx_prev_q;
    logic                  rx_par_en_q, rx_par_odd_q, rx_par_bad_q, rx_done_q, rx_stop_ok_q;

    logic wr, rd, data_wr, data_rd, clr_err, tx_flush, rx_flush;
    logic tx_full, tx_empty, rx_full, rx_empty, tx_busy, tx_load, tx_push, rx_push, rx_pop;
    logic [DATA_WIDTH-1:0] status, rd_data;

    assign wr       = bus.cpu_cs & bus.cpu_we;
    assign rd       = bus.cpu_cs & bus.cpu_re;
    assign data_wr  = wr && (bus.cpu_addr == 2'd2);
    assign data_rd  = rd && (bus.cpu_addr == 2'd2);
    assign clr_err  = wr && (bus.cpu_addr == 2'd3) && bus.cpu_din[0];
    assign tx_flush = wr && (bus.cpu_addr == 2'd3) && bus.cpu_din[1];
    assign rx_flush = wr && (bus.cpu_addr == 2'd3) && bus.cpu_din[2];

    assign tx_full  = (tx_cnt_q == FULL_CNT);
    assign tx_empty = (tx_cnt_q == '0);
    assign rx_full  = (rx_cnt_q == FULL_CNT);
    assign rx_empty = (rx_cnt_q == '0);
    assign tx_busy  = (tx_state_q != S_UART_TX_IDLE);

    // The shifter reloads straight from STOP so queued frames run back to back
    assign tx_load = !tx_empty && ((tx_state_q == S_UART_TX_IDLE) ||
                                   (tx_state_q == S_UART_TX_STOP && tx_tick_q == BIT_END));
    assign tx_push = data_wr && (!tx_full || tx_load);
    assign rx_push = rx_wr_q && !rx_full;
    assign rx_pop  = data_rd && !rx_empty;

    assign irq      = (cfg_q[2] & !rx_empty) | (cfg_q[3] & tx_empty);
    assign uart_tx  = uart_tx_q;
    assign bus.cpu_dout = dout_q;

    // Register read mux and STATUS packing
    always_comb begin
        status      = '0;
        status[7:0] = {err_q, rx_full, !rx_empty, tx_busy, tx_empty, tx_full};
        rd_data     = '0;
        case (bus.cpu_addr)
            2'd0:    rd_data[3:0] = cfg_q;
            2'd1:    rd_data = status;
            2'd2:    rd_data = rx_empty ? '0 : rx_mem[rx_rptr_q];
            default: rd_data = '0;
        endcase
    end

    // Next state for config, sticky errors, read data, FIFO pointers and the RX push pipeline
    always_comb begin
        cfg_d  = (wr && bus.cpu_addr == 2'd0) ? bus.cpu_din[3:0] : cfg_q;
        dout_d = rd ? rd_data : dout_q;
        err_d  = clr_err ? 3'b000 : err_q;
        err_d  = err_d | {rx_par_set_q, rx_frame_set_q, rx_wr_q && rx_full};

        rx_wr_d        = rx_done_q && rx_stop_ok_q;
        rx_frame_set_d = rx_done_q && !rx_stop_ok_q;
        rx_par_set_d   = rx_done_q && rx_par_bad_q;

        tx_wptr_d = tx_wptr_q;
        tx_rptr_d = tx_rptr_q;
        tx_cnt_d  = tx_cnt_q;
        if (tx_flush) begin
            tx_wptr_d = '0;
            tx_rptr_d = '0;
            tx_cnt_d  = '0;
        end else begin
            if (tx_push) tx_wptr_d = tx_wptr_q + AW'(1);
            if (tx_load) tx_rptr_d = tx_rptr_q + AW'(1);
            case ({tx_push, tx_load})
                2'b10:   tx_cnt_d = tx_cnt_q + CW'(1);
                2'b01:   tx_cnt_d = tx_cnt_q - CW'(1);
                default: tx_cnt_d = tx_cnt_q;
            endcase
        end

        rx_wptr_d = rx_wptr_q;
        rx_rptr_d = rx_rptr_q;
        rx_cnt_d  = rx_cnt_q;
        if (rx_flush) begin
            rx_wptr_d = '0;
            rx_rptr_d = '0;
            rx_cnt_d  = '0;
        end else begin
            if (rx_push) rx_wptr_d = rx_wptr_q + AW'(1);
            if (rx_pop)  rx_rptr_d = rx_rptr_q + AW'(1);
            case ({rx_push, rx_pop})
                2'b10:   rx_cnt_d = rx_cnt_q + CW'(1);
                2'b01:   rx_cnt_d = rx_cnt_q - CW'(1);
                default: rx_cnt_d = rx_cnt_q;
            endcase
        end
    end

    // Register the bus-side state
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cfg_q <= '0; err_q <= '0; dout_q <= '0;
            tx_wptr_q <= '0; tx_rptr_q <= '0; tx_cnt_q <= '0;
            rx_wptr_q <= '0; rx_rptr_q <= '0; rx_cnt_q <= '0;
            rx_wr_q <= 1'b0; rx_frame_set_q <= 1'b0; rx_par_set_q <= 1'b0;
        end else begin
            cfg_q <= cfg_d; err_q <= err_d; dout_q <= dout_d;
            tx_wptr_q <= tx_wptr_d; tx_rptr_q <= tx_rptr_d; tx_cnt_q <= tx_cnt_d;
            rx_wptr_q <= rx_wptr_d; rx_rptr_q <= rx_rptr_d; rx_cnt_q <= rx_cnt_d;
            rx_wr_q <= rx_wr_d; rx_frame_set_q <= rx_frame_set_d; rx_par_set_q <= rx_par_set_d;
        end
    end

    // FIFO storage; contents are meaningless once the counts are cleared
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wptr_q] <= bus.cpu_din;
        if (rx_push) rx_mem[rx_wptr_q] <= rx_shift_q;
    end

    // TX frame sequencer; parity settings are captured with the character
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tx_state_q <= S_UART_TX_IDLE; tx_tick_q <= '0; tx_bit_q <= '0; tx_shift_q <= '0;
            tx_par_en_q <= 1'b0; tx_par_bit_q <= 1'b0; uart_tx_q <= 1'b1;
        end else if (tx_load) begin
            tx_shift_q   <= tx_mem[tx_rptr_q];
            tx_par_en_q  <= cfg_q[0];
            tx_par_bit_q <= (^tx_mem[tx_rptr_q]) ^ cfg_q[1];
            tx_tick_q    <= '0;
            uart_tx_q    <= 1'b0;
            tx_state_q   <= S_UART_TX_START;
        end else begin
            tx_tick_q <= (tx_tick_q == BIT_END) ? '0 : tx_tick_q + TW'(1);
            case (tx_state_q)
                S_UART_TX_IDLE: begin
                    tx_tick_q <= '0;
                    uart_tx_q <= 1'b1;
                end
                S_UART_TX_START: if (tx_tick_q == BIT_END) begin
                    tx_bit_q   <= '0;
                    uart_tx_q  <= tx_shift_q[0];
                    tx_state_q <= S_UART_TX_SEND_DATA;
                end
                S_UART_TX_SEND_DATA: if (tx_tick_q == BIT_END) begin
                    if (tx_bit_q == LAST_BIT) begin
                        uart_tx_q  <= tx_par_en_q ? tx_par_bit_q : 1'b1;
                        tx_state_q <= tx_par_en_q ? S_UART_TX_PARITY : S_UART_TX_STOP;
                    end else begin
                        tx_bit_q   <= tx_bit_q + BW'(1);
                        tx_shift_q <= tx_shift_q >> 1;
                        uart_tx_q  <= tx_shift_q[1];
                    end
                end
                S_UART_TX_PARITY: if (tx_tick_q == BIT_END) begin
                    uart_tx_q  <= 1'b1;
                    tx_state_q <= S_UART_TX_STOP;
                end
                S_UART_TX_STOP: if (tx_tick_q == BIT_END) begin
                    uart_tx_q  <= 1'b1;
                    tx_state_q <= S_UART_TX_IDLE;
                end
                default: tx_state_q <= S_UART_TX_IDLE;
            endcase
        end
    end

    // RX synchroniser and mid-bit sampler; emits a one-cycle done pulse at the stop sample
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rx_meta_q <= 1'b1; rx_sync_q <= 1'b1; rx_prev_q <= 1'b1;
            rx_state_q <= S_UART_RX_IDLE; rx_tick_q <= '0; rx_bit_q <= '0; rx_shift_q <= '0;
            rx_par_en_q <= 1'b0; rx_par_odd_q <= 1'b0; rx_par_bad_q <= 1'b0;
            rx_done_q <= 1'b0; rx_stop_ok_q <= 1'b0;
        end else begin
            rx_meta_q <= uart_rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
            rx_done_q <= 1'b0;
            rx_tick_q <= rx_tick_q + TW'(1);
            case (rx_state_q)
                S_UART_RX_IDLE: begin
                    rx_tick_q <= '0;
                    if (rx_prev_q && !rx_sync_q) rx_state_q <= S_UART_RX_VALIDATE_START;
                end
                S_UART_RX_VALIDATE_START: if (rx_tick_q == HALF_END) begin
                    rx_tick_q <= '0;
                    if (!rx_sync_q) begin
                        rx_bit_q     <= '0;
                        rx_par_en_q  <= cfg_q[0];
                        rx_par_odd_q <= cfg_q[1];
                        rx_par_bad_q <= 1'b0;
                        rx_state_q   <= S_UART_RX_READ_DATA;
                    end else begin
                        rx_state_q <= S_UART_RX_IDLE;
                    end
                end
                S_UART_RX_READ_DATA: if (rx_tick_q == BIT_END) begin
                    rx_tick_q  <= '0;
                    rx_shift_q <= {rx_sync_q, rx_shift_q[DATA_WIDTH-1:1]};
                    if (rx_bit_q == LAST_BIT)
                        rx_state_q <= rx_par_en_q ? S_UART_RX_PARITY : S_UART_RX_STOP;
                    else
                        rx_bit_q <= rx_bit_q + BW'(1);
                end
                S_UART_RX_PARITY: if (rx_tick_q == BIT_END) begin
                    rx_tick_q    <= '0;
                    rx_par_bad_q <= ((^rx_shift_q) ^ rx_sync_q) != rx_par_odd_q;
                    rx_state_q   <= S_UART_RX_STOP;
                end
                S_UART_RX_STOP: if (rx_tick_q == BIT_END) begin
                    rx_tick_q    <= '0;
                    rx_done_q    <= 1'b1;
                    rx_stop_ok_q <= rx_sync_q;
                    rx_state_q   <= S_UART_RX_IDLE;
                end
                default: rx_state_q <= S_UART_RX_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_mmio.sv
// tb/tb_uart_mmio.sv - directed self-checking bench for uart_mmio
module tb_uart_mmio;
    localparam int CPB = 8;
    localparam int FD  = 4;
    localparam int DW  = 8;

    logic clk = 1'b0;
    logic reset_n;
    logic rx_drv;
    logic loop_en;
    logic rx_line;
    logic uart_tx;
    logic irq;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    assign rx_line = loop_en ? uart_tx : rx_drv;

    uart_mmio_if #(.DATA_WIDTH(DW)) bus ();

    uart_mmio #(.DATA_WIDTH(DW), .FIFO_DEPTH(FD), .CLKS_PER_BIT(CPB)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus),
        .uart_rx (rx_line),
        .uart_tx (uart_tx),
        .irq     (irq)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Bus tasks start and end just after a falling edge; the access lands on the rising edge between
    task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
        bus.cpu_cs = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = a; bus.cpu_din = d;
        @(negedge clk);
        bus.cpu_cs = 1'b0; bus.cpu_we = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
        bus.cpu_cs = 1'b1; bus.cpu_re = 1'b1; bus.cpu_addr = a;
        @(negedge clk);
        bus.cpu_cs = 1'b0; bus.cpu_re = 1'b0;
        d = bus.cpu_dout;
    endtask

    task automatic tx_capture(input int first_wait, input int nbits, output logic [63:0] bits);
        bits = '0;
        for (int i = 0; i < nbits; i++) begin
            repeat ((i == 0) ? first_wait : CPB) @(posedge clk);
            @(negedge clk);
            bits[i] = uart_tx;
        end
    endtask

    task automatic rx_send(input logic [7:0] d, input logic par_en, input logic par_bit, input logic stop);
        rx_drv = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_drv = d[i];
            repeat (CPB) @(negedge clk);
        end
        if (par_en) begin
            rx_drv = par_bit;
            repeat (CPB) @(negedge clk);
        end
        rx_drv = stop;
        repeat (CPB) @(negedge clk);
        rx_drv = 1'b1;
        repeat (2 * CPB) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [7:0]  d;
        logic [63:0] bits;
        reset_n = 1'b0; rx_drv = 1'b1; loop_en = 1'b0;
        bus.cpu_cs = 1'b0; bus.cpu_we = 1'b0; bus.cpu_re = 1'b0; bus.cpu_addr = 2'd0; bus.cpu_din = 8'h00;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        check("rst_uart_tx", uart_tx, 1);
        check("rst_irq", irq, 0);
        check("rst_dout", bus.cpu_dout, 0);
        bus_read(2'd1, d);
        check("rst_status", d, 8'h02);

        // Single character, parity off
        fork
            bus_write(2'd2, 8'hA5);
            tx_capture(2 + CPB / 2, 10, bits);
        join
        check("frame_a5", bits[9:0], 10'b1_1010_0101_0);
        repeat (CPB / 2 - 1) @(posedge clk);
        @(negedge clk);
        bus_read(2'd1, d);
        check("busy_last_cycle", d, 8'h06);
        bus_read(2'd1, d);
        check("busy_cleared", d, 8'h02);

        // FIFO_DEPTH+2 writes: one popped at once, FIFO_DEPTH queued, the last dropped
        fork
            begin
                for (int i = 0; i < FD + 2; i++) bus_write(2'd2, 8'((i + 1) * 17));
                bus_read(2'd1, d);
                check("tx_full_status", d, 8'h05);
            end
            tx_capture(2 + CPB / 2, 10 * (FD + 1), bits);
        join
        for (int k = 0; k < FD + 1; k++)
            check($sformatf("queued_frame%0d", k), bits[k*10 +: 10], {1'b1, 8'((k + 1) * 17), 1'b0});
        repeat (2 * CPB) @(negedge clk);
        check("after_queue_tx_idle", uart_tx, 1);
        bus_read(2'd1, d);
        check("dropped_not_sent", d, 8'h02);

        // Reset in the middle of a frame
        bus_write(2'd2, 8'h00);
        repeat (CPB + 3) @(negedge clk);
        check("midframe_tx_low", uart_tx, 0);
        reset_n = 1'b0;
        @(negedge clk);
        check("midframe_reset_tx", uart_tx, 1);
        reset_n = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        bus_read(2'd1, d);
        check("midframe_reset_status", d, 8'h02);

        // Loopback with odd parity
        bus_write(2'd0, 8'h03);
        loop_en = 1'b1;
        bus_write(2'd2, 8'h3C);
        repeat (12 * CPB + 8) @(negedge clk);
        bus_read(2'd1, d);
        check("loop_status", d, 8'h0A);
        bus_read(2'd2, d);
        check("loop_data", d, 8'h3C);
        bus_read(2'd2, d);
        check("loop_empty_read", d, 8'h00);
        bus_read(2'd0, d);
        check("config_readback", d, 8'h03);
        loop_en = 1'b0;

        // Even parity with a wrong parity bit: flagged, byte still kept
        bus_write(2'd0, 8'h01);
        rx_send(8'h01, 1'b1, 1'b0, 1'b1);
        bus_read(2'd1, d);
        check("parity_err_status", d, 8'h8A);
        bus_read(2'd2, d);
        check("parity_err_data", d, 8'h01);
        bus_write(2'd3, 8'h01);
        bus_write(2'd0, 8'h00);

        // Stop bit low: frame error, nothing pushed, then cleared
        rx_send(8'h5A, 1'b0, 1'b0, 1'b0);
        bus_read(2'd1, d);
        check("frame_err_status", d, 8'h42);
        bus_write(2'd3, 8'h01);
        bus_read(2'd1, d);
        check("frame_err_cleared", d, 8'h02);

        // Overrun, irq, RX flush
        for (int k = 0; k < FD + 1; k++) rx_send(8'((k + 1) * 16), 1'b0, 1'b0, 1'b1);
        bus_read(2'd1, d);
        check("overrun_status", d, 8'h3A);
        bus_write(2'd0, 8'h04);
        check("rx_irq_on", irq, 1);
        bus_read(2'd2, d);
        check("overrun_data0", d, 8'h10);
        bus_read(2'd2, d);
        check("overrun_data1", d, 8'h20);
        bus_write(2'd3, 8'h04);
        check("rx_irq_off_after_flush", irq, 0);
        bus_read(2'd1, d);
        check("flushed_status", d, 8'h22);
        bus_write(2'd0, 8'h08);
        check("tx_irq_on_empty", irq, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/uart_mmio.md
# uart_mmio

Memory-mapped UART peripheral for the SAP-2 system bus: the parametrised successor of the fixed-format UART. Adds TX and RX FIFOs, optional runtime parity, sticky error flags, FIFO flush commands and an interrupt output. It decodes the four-register window CONFIG/STATUS/DATA/COMMAND at offsets 0–3 and drives the serial TX/RX pins.

## Interface
- DATA_WIDTH, 8: CPU bus width and serial character width.
- FIFO_DEPTH, 4: entries per FIFO. Must be a power of two, ≥2.
- CLKS_PER_BIT, 174: clk cycles per serial bit. Must be ≥4 and even.

- clk  in  1  system clock; all logic on the rising edge.
- reset_n  in  1  reset, synchronous and active-low.
- cpu_cs  in  1  peripheral select; qualifies we/re.
- cpu_we  in  1  write strobe, one cycle per access.
- cpu_re  in  1  read strobe, one cycle per access.
- cpu_addr  in  2  register offset: 0 CONFIG, 1 STATUS, 2 DATA, 3 COMMAND.
- cpu_din  in  DATA_WIDTH  write data.
- cpu_dout  out  DATA_WIDTH  registered read data.
- uart_rx  in  1  serial input; asynchronous to clk.
- uart_tx  out  1  serial output, registered; idles high.
- irq  out  1  level interrupt.

## Operation
- CONFIG (RW, reset 0x00):
  - bit0 parity_en; bit1 parity_odd (0 = even).
  - bit2 rx_irq_en; bit3 tx_irq_en.
  - Upper bits read 0.
- STATUS (RO), one bit each:
  - bit0 tx_full; bit1 tx_empty; bit2 tx_busy; bit3 rx_valid (RX FIFO non-empty); bit4 rx_full.
  - Sticky: bit5 overrun, bit6 frame_err, bit7 parity_err.
- DATA:
  - Write pushes the TX FIFO. Silently dropped if the FIFO is full.
  - Read returns the RX FIFO head and pops it.
  - Reading an empty RX FIFO returns 0x00 with no pop.
- COMMAND (WO, reads 0x00), bits act for one cycle:
  - bit0 clears the three sticky errors.
  - bit1 flushes the TX FIFO.
  - bit2 flushes the RX FIFO.
  - A flush never aborts a frame in progress.
- Frame format, LSB first: start (0), DATA_WIDTH data bits, parity bit if parity_en, one stop bit (1).
- TX FSM states:
  - S_UART_TX_IDLE: on FIFO non-empty, pop the head into the shifter and go to START.
  - START → SEND_DATA → PARITY (only if parity_en) → STOP → IDLE.
  - Each state lasts CLKS_PER_BIT cycles.
  - parity_en/parity_odd are latched at pop, so a CONFIG write mid-frame does not affect the current frame.
- RX path:
  - uart_rx passes through a 2-flop synchroniser (reset 1).
  - IDLE: a high→low edge goes to VALIDATE_START.
  - VALIDATE_START: wait CLKS_PER_BIT/2 cycles. Line still low → READ_DATA; line high → IDLE (glitch rejected, nothing flagged).
  - READ_DATA, PARITY, STOP: sample each bit CLKS_PER_BIT cycles after the previous sample (mid-bit).
  - STOP sample 0: set frame_err, discard the byte.
  - Parity mismatch: set parity_err, still push the byte.
  - RX FIFO full at push: drop the byte, set overrun.
  - After the stop sample, return to IDLE immediately.
- irq = (rx_irq_en & rx_valid) | (tx_irq_en & tx_empty); combinational from registered state.
- Boundary rules:
  - Push and pop on the same FIFO in one cycle: both occur, count unchanged. Legal when full (TX only).
  - Flush and push in the same cycle: flush wins, the push is lost.
  - Error clear and error set in the same cycle: the flag ends set.
  - CPU read of DATA in the same cycle as an RX push into an empty FIFO: returns 0x00, byte remains.
  - FIFO pointers wrap modulo FIFO_DEPTH. A count of DATA_WIDTH-independent width $clog2(FIFO_DEPTH)+1 distinguishes full from empty.

## Timing
- Reset values:
  - uart_tx=1, cpu_dout=0x00, irq=0.
  - CONFIG=0x00, both FIFOs empty, sticky errors 0.
  - FSMs in IDLE; STATUS reads 0x02.
- Reset asserted mid-frame: uart_tx=1 after the next edge, frame abandoned, FIFO contents lost.
- Read latency: cpu_dout is valid on the edge after the read strobe edge and holds until the next read.
- TX latency: a DATA write at edge E0 with the TX FIFO empty and the FSM idle pops at E1; uart_tx goes low from E1.
- Frame duration: (10 + parity_en)·CLKS_PER_BIT cycles. Queued frames follow with zero idle bits.
- tx_busy is 1 from the pop edge until STOP completes.
- RX: the byte becomes visible in STATUS.rx_valid 2 cycles after the stop-sample edge.

## Test plan
- Reset, then read STATUS → 0x02; uart_tx=1; irq=0.
- Write 0xA5 to DATA with parity off → uart_tx carries 0,1,0,1,0,0,1,0,1,1, each held CLKS_PER_BIT cycles; tx_busy clears after 10·CLKS_PER_BIT cycles.
- Write FIFO_DEPTH+2 bytes back-to-back:
  - tx_full asserts.
  - The last writes that land while full are dropped.
  - FIFO_DEPTH+1 frames are transmitted: one popped immediately, plus FIFO_DEPTH queued. Frames are contiguous.
- Loop uart_tx to uart_rx, CONFIG=0x03 (odd parity), send 0x3C:
  - rx_valid=1.
  - DATA read → 0x3C.
  - STATUS parity_err=0.
  - A second DATA read → 0x00.
- Drive an RX frame with stop=0 → frame_err=1, no push. COMMAND=0x01 → STATUS bit6 clears.
- Receive FIFO_DEPTH+1 bytes with no reads → rx_full=1, overrun=1, first FIFO_DEPTH bytes intact. CONFIG rx_irq_en=1 → irq=1. COMMAND=0x04 → rx_valid=0, irq=0.
